// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The master side feeds the stream; the slave side is the loader itself.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, we, waddr, wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into program memory
// one word at a time, holding the CPU in reset while a session is active.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    prog_loader_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IW    = ADDR_WIDTH + 1;
    localparam int CW    = (IW > 8) ? IW : 8;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

    state_t                state;
    logic [7:0]            len;
    logic [7:0]            acc;
    logic [IW-1:0]         word_idx;
    logic [BW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  active;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  done_q;
    logic                  error_q;

    logic                  take;
    logic                  too_big;
    logic                  last_byte;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] word_next;

    // Word count L+1 exceeds the depth exactly when L >= 2^ADDR_WIDTH.
    assign take      = bus.rx_valid && active;
    assign too_big   = CW'(bus.rx_data) >= (CW'(1) << ADDR_WIDTH);
    assign last_byte = byte_idx == BW'(BYTES - 1);
    assign last_word = CW'(word_idx) == CW'(len);
    assign word_next = DATA_WIDTH'({shift, bus.rx_data});

    assign bus.rx_ready = active;
    assign bus.busy     = active;
    assign bus.cpu_hold = active;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // reads within the block see the pre-edge values, which the datapath relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            acc      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            shift    <= '0;
            active   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state    <= LEN;
                        active   <= 1'b1;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        acc      <= '0;
                    end
                end
                LEN: begin
                    if (take) begin
                        len <= bus.rx_data;
                        acc <= bus.rx_data;
                        if (too_big) begin
                            state   <= ERR;
                            active  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        shift <= word_next;
                        acc   <= acc ^ bus.rx_data;
                        if (last_byte) begin
                            byte_idx <= '0;
                            we_q     <= 1'b1;
                            waddr_q  <= word_idx[ADDR_WIDTH-1:0];
                            wdata_q  <= word_next;
                            if (last_word) state <= CHK;
                            else           word_idx <= word_idx + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (take) begin
                        active <= 1'b0;
                        if (bus.rx_data == acc) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad loads, stalls, full depth,
// out-of-range length on a shallow instance, and reset mid-word.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();
    prog_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus4 ();

    prog_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    prog_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int w4    = 0;
    logic [7:0]  wa_q [$];
    logic [15:0] wd_q [$];

    // Write log, sampled mid-cycle; a stuck or doubled strobe shows up as extra entries.
    always @(negedge clk) begin
        if (bus.we) begin
            wa_q.push_back(bus.waddr);
            wd_q.push_back(bus.wdata);
        end
        if (bus4.we) w4++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!bus.rx_ready && n <= 50) begin
            @(negedge clk);
            n++;
        end
        if (n > 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL rx_ready_timeout: observed 0 expected 1");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.start    = st;
        wait_accept();
    endtask

    task automatic gap(input int k, input logic st);
        repeat (k) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.start    = st;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwrites"}, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check({tag, "_addr0"}, wa_q[0], 8'h00);
            check({tag, "_data0"}, wd_q[0], 16'h1234);
            check({tag, "_addr1"}, wa_q[1], 8'h01);
            check({tag, "_data1"}, wd_q[1], 16'hABCD);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, bus.rx_ready, 0);
        check({tag, "_we"},       bus.we, 0);
        check({tag, "_waddr"},    bus.waddr, 0);
        check({tag, "_wdata"},    bus.wdata, 0);
        check({tag, "_cpu_hold"}, bus.cpu_hold, 0);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_error"},    bus.error, 0);
    endtask

    initial begin
        logic [7:0] acc;

        // Reset with arbitrary inputs applied.
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 8'($urandom);
        bus4.start    = 1'b0;
        bus4.rx_valid = 1'b0;
        bus4.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset4_busy", bus4.busy, 0);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        rst          = 1'b0;

        // rx_valid activity in IDLE must be ignored.
        repeat (4) begin
            @(negedge clk);
            bus.rx_valid = ~bus.rx_valid;
            bus.rx_data  = 8'($urandom);
        end
        idle();
        check("idle_rx_ready", bus.rx_ready, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_nwrites", wa_q.size(), 0);

        // Good load, opening with start and rx_valid together: the byte waits.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h01;
        @(negedge clk);
        check("start_rx_ready", bus.rx_ready, 1);
        check("start_cpu_hold", bus.cpu_hold, 1);
        bus.start = 1'b0;
        wait_accept();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h41, 1'b0);
        idle();
        check("good_done", bus.done, 1);
        check("good_error", bus.error, 0);
        check("good_busy", bus.busy, 0);
        check("good_cpu_hold", bus.cpu_hold, 0);
        repeat (2) @(negedge clk);
        check_two_words("good");
        check("good_hold_waddr", bus.waddr, 8'h01);
        check("good_hold_wdata", bus.wdata, 16'hABCD);

        // Bad checksum: writes still land, error reported.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        check("bad_done_cleared", bus.done, 0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h40, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        check("bad_error", bus.error, 1);
        check("bad_done", bus.done, 0);
        check("bad_busy", bus.busy, 0);
        check_two_words("bad");

        // Stalls and stray start pulses mid-session.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        check("stall_error_cleared", bus.error, 0);
        gap(2, 1'b0);
        send_byte(8'h01, 1'b1);
        gap(1, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        gap(3, 1'b1);
        send_byte(8'hAB, 1'b0);
        gap(1, 1'b0);
        send_byte(8'hCD, 1'b1);
        gap(2, 1'b1);
        send_byte(8'h41, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        check("stall_done", bus.done, 1);
        check("stall_busy", bus.busy, 0);
        check_two_words("stall");

        // Full depth: 256 words, word i = {i, ~i}.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'hFF, 1'b0);
        acc = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(~8'(i), 1'b0);
            acc = acc ^ 8'(i) ^ ~8'(i);
        end
        send_byte(acc, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        check("full_done", bus.done, 1);
        check("full_nwrites", wa_q.size(), 256);
        if (wa_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                check($sformatf("full_addr%0d", i), wa_q[i], 32'(i));
                check($sformatf("full_data%0d", i), wd_q[i], {8'(i), ~8'(i)});
            end
        end

        // Length beyond a 16-word memory: error right after the length byte.
        @(negedge clk);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("range_rx_ready_len", bus4.rx_ready, 1);
        bus4.rx_valid = 1'b1;
        bus4.rx_data  = 8'h10;
        @(negedge clk);
        bus4.rx_valid = 1'b0;
        check("range_error", bus4.error, 1);
        check("range_done", bus4.done, 0);
        check("range_rx_ready", bus4.rx_ready, 0);
        check("range_busy", bus4.busy, 0);
        repeat (2) @(negedge clk);
        check("range_nwrites", w4, 0);

        // Reset after the first data byte, then a fresh single-word session.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst          = 1'b0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h2E, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        check("midrst_done", bus.done, 1);
        check("midrst_nwrites", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("midrst_addr", wa_q[0], 8'h00);
            check("midrst_data", wd_q[0], 16'h5678);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
